pkt_proc_fifo: RTL and testbench

Parametrised packet buffer that hands each complete packet to the in-line RISC-V datapath for processing before forwarding it downstream. It sits between the upstream packet interface and the next pipeline stage. It generalises the single-buffer SRAM FIFO as follows:
- configurable data/ctrl width, depth and almost-full margin;
- a stored-packet length queue, so input keeps streaming while one packet is processed;
- a head-relative processor port;
- a three-state fill/process/drain controller.

---
 rtl/pkt_proc_fifo.sv | 180 ++++++++++++++++++
 tb/tb_pkt_proc_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_proc_fifo.sv
// Packet buffer: stores whole packets, lends the head packet to the processor, then drains it.
// Optional macro PKT_PROC_FIFO_DROP_EN lets the processor discard the head packet.
module pkt_proc_fifo #(
    parameter int DWIDTH         = 64,
    parameter int CWIDTH         = 8,
    parameter int AWIDTH         = 8,
    parameter int LAWIDTH        = 3,
    parameter int ALMFULL_MARGIN = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [DWIDTH-1:0]          in_data,
    input  logic [CWIDTH-1:0]          in_ctrl,
    input  logic                       in_wr,
    output logic                       in_rdy,
    output logic [DWIDTH-1:0]          out_data,
    output logic [CWIDTH-1:0]          out_ctrl,
    output logic                       out_wr,
    input  logic                       out_rdy,
    input  logic [AWIDTH-1:0]          proc_addr,
    input  logic [DWIDTH+CWIDTH-1:0]   proc_din,
    input  logic                       proc_we,
    output logic [DWIDTH+CWIDTH-1:0]   proc_dout,
    output logic                       proc_start,
    output logic [AWIDTH:0]            pkt_len,
    input  logic                       proc_done,
    input  logic                       proc_drop,
    output logic [1:0]                 state,
    output logic                       ovf
);
    localparam int WW     = DWIDTH + CWIDTH;
    localparam int DEPTH  = 1 << AWIDTH;
    localparam int LDEPTH = 1 << LAWIDTH;
    localparam logic [AWIDTH:0] ONE      = (AWIDTH+1)'(1);
    localparam logic [AWIDTH:0] FILL_MAX = (AWIDTH+1)'(DEPTH - ALMFULL_MARGIN);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PROC = 2'd1, S_DRAIN = 2'd2} state_t;

    logic [WW-1:0]      mem [DEPTH];
    logic [AWIDTH:0]    lq_mem [LDEPTH];

    state_t             state_q;
    logic [AWIDTH-1:0]  wr_ptr_q, wr_ptr_d, head_q, head_d;
    logic [AWIDTH:0]    count_q, count_d, len_q, len_d, rd_off_q, pkt_len_q;
    logic [LAWIDTH:0]   lq_wr_q, lq_wr_d, lq_rd_q, lq_rd_d;
    logic               seen_zero_q, seen_zero_d, ovf_q, proc_start_q, out_wr_q;
    logic [WW-1:0]      out_word_q, proc_dout_q;

    logic               lq_empty, lq_full, wr_acc, eop, in_range, proc_wr;
    logic               rd_issue, last_rd, drop_act, pop;
    logic [AWIDTH-1:0]  b_addr;

    assign lq_empty = (lq_wr_q == lq_rd_q);
    assign lq_full  = (lq_wr_q[LAWIDTH] != lq_rd_q[LAWIDTH]) &&
                      (lq_wr_q[LAWIDTH-1:0] == lq_rd_q[LAWIDTH-1:0]);
    assign in_rdy   = (count_q < FILL_MAX) && !lq_full;
    assign wr_acc   = in_wr && in_rdy;
    // A nonzero ctrl only ends a packet once a zero-ctrl body word has been seen
    assign eop      = wr_acc && (in_ctrl != '0) && seen_zero_q;

    assign in_range = ({1'b0, proc_addr} < pkt_len_q);
    assign b_addr   = head_q + ((state_q == S_DRAIN) ? rd_off_q[AWIDTH-1:0] : proc_addr);
    assign rd_issue = (state_q == S_DRAIN) && out_rdy;
    assign last_rd  = rd_issue && (rd_off_q == pkt_len_q - ONE);

`ifdef PKT_PROC_FIFO_DROP_EN
    assign drop_act = (state_q == S_PROC) && proc_drop;
`else
    logic unused_drop;
    assign unused_drop = proc_drop;
    assign drop_act    = 1'b0;
`endif

    assign proc_wr  = (state_q == S_PROC) && proc_we && in_range && !drop_act;
    assign pop      = last_rd || drop_act;

    always_comb begin
        wr_ptr_d    = wr_acc ? wr_ptr_q + AWIDTH'(1) : wr_ptr_q;
        head_d      = pop ? head_q + pkt_len_q[AWIDTH-1:0] : head_q;
        lq_wr_d     = eop ? lq_wr_q + (LAWIDTH+1)'(1) : lq_wr_q;
        lq_rd_d     = pop ? lq_rd_q + (LAWIDTH+1)'(1) : lq_rd_q;
        count_d     = count_q + (wr_acc ? ONE : '0) - (rd_issue ? ONE : '0)
                      - (drop_act ? pkt_len_q : '0);
        len_d       = len_q;
        seen_zero_d = seen_zero_q;
        if (eop) begin
            len_d       = '0;
            seen_zero_d = 1'b0;
        end else if (wr_acc) begin
            len_d = len_q + ONE;
            if (in_ctrl == '0)
                seen_zero_d = 1'b1;
        end
    end

    // Storage: port A takes input words, port B takes processor writes
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr_q] <= {in_ctrl, in_data};
        if (proc_wr)
            mem[b_addr] <= proc_din;
        if (eop)
            lq_mem[lq_wr_q[LAWIDTH-1:0]] <= len_q + ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            head_q      <= '0;
            count_q     <= '0;
            len_q       <= '0;
            seen_zero_q <= 1'b0;
            lq_wr_q     <= '0;
            lq_rd_q     <= '0;
            ovf_q       <= 1'b0;
            proc_dout_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            head_q      <= head_d;
            count_q     <= count_d;
            len_q       <= len_d;
            seen_zero_q <= seen_zero_d;
            lq_wr_q     <= lq_wr_d;
            lq_rd_q     <= lq_rd_d;
            if (in_wr && !in_rdy)
                ovf_q <= 1'b1;
            proc_dout_q <= ((state_q == S_PROC) && in_range) ? mem[b_addr] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pkt_len_q    <= '0;
            rd_off_q     <= '0;
            proc_start_q <= 1'b0;
            out_wr_q     <= 1'b0;
            out_word_q   <= '0;
        end else begin
            proc_start_q <= 1'b0;
            out_wr_q     <= rd_issue;
            if (rd_issue)
                out_word_q <= mem[b_addr];
            case (state_q)
                S_IDLE: begin
                    if (!lq_empty) begin
                        pkt_len_q    <= lq_mem[lq_rd_q[LAWIDTH-1:0]];
                        proc_start_q <= 1'b1;
                        state_q      <= S_PROC;
                    end
                end
                S_PROC: begin
                    if (drop_act) begin
                        state_q <= S_IDLE;
                    end else if (proc_done) begin
                        rd_off_q <= '0;
                        state_q  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (rd_issue) begin
                        rd_off_q <= rd_off_q + ONE;
                        if (last_rd)
                            state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_data   = out_word_q[DWIDTH-1:0];
    assign out_ctrl   = out_word_q[WW-1:DWIDTH];
    assign out_wr     = out_wr_q;
    assign proc_dout  = proc_dout_q;
    assign proc_start = proc_start_q;
    assign pkt_len    = pkt_len_q;
    assign state      = state_q;
    assign ovf        = ovf_q;
endmodule

// File: tb/tb_pkt_proc_fifo.sv
// Scoreboard bench for pkt_proc_fifo built with a 16-word buffer and a 2-word margin.
module tb_pkt_proc_fifo;
    localparam int DW = 64, CW = 8, AW = 4, LAW = 3, MARG = 2, WW = 72;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic [CW-1:0]  in_ctrl = '0;
    logic           in_wr = 1'b0, in_rdy;
    logic [DW-1:0]  out_data;
    logic [CW-1:0]  out_ctrl;
    logic           out_wr, out_rdy = 1'b1;
    logic [AW-1:0]  proc_addr = '0;
    logic [WW-1:0]  proc_din = '0, proc_dout;
    logic           proc_we = 1'b0, proc_start;
    logic [AW:0]    pkt_len;
    logic           proc_done = 1'b0, proc_drop = 1'b0;
    logic [1:0]     state;
    logic           ovf;

    int             n_tests = 0, n_fail = 0;
    logic [WW-1:0]  exp_q[$];

    always #5 clk = ~clk;

    pkt_proc_fifo #(.DWIDTH(DW), .CWIDTH(CW), .AWIDTH(AW), .LAWIDTH(LAW),
                    .ALMFULL_MARGIN(MARG)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_ctrl(in_ctrl),
        .in_wr(in_wr), .in_rdy(in_rdy), .out_data(out_data), .out_ctrl(out_ctrl),
        .out_wr(out_wr), .out_rdy(out_rdy), .proc_addr(proc_addr), .proc_din(proc_din),
        .proc_we(proc_we), .proc_dout(proc_dout), .proc_start(proc_start),
        .pkt_len(pkt_len), .proc_done(proc_done), .proc_drop(proc_drop),
        .state(state), .ovf(ovf));

    task automatic put_word(input logic [CW-1:0] c, input logic [DW-1:0] d, output bit acc);
        @(negedge clk);
        in_wr = 1'b1; in_ctrl = c; in_data = d;
        acc = in_rdy;
        if (acc) exp_q.push_back({c, d});
    endtask

    task automatic send_pkt(input int len, input logic [31:0] base);
        bit acc;
        logic [CW-1:0] c;
        for (int i = 0; i < len; i++) begin
            c = (i == 0) ? 8'hFF : ((i == len - 1) ? 8'h04 : 8'h00);
            put_word(c, {base, 32'(i)}, acc);
            n_tests++;
            if (!acc) begin n_fail++; $display("FAIL accept word %0d of pkt %h: in_rdy=0, want 1", i, base); end
        end
        @(negedge clk);
        in_wr = 1'b0;
    endtask

    task automatic wait_proc(input int len, output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (state !== 2'd1 && cyc < 50);
        n_tests++;
        if (state !== 2'd1) begin n_fail++; $display("FAIL proc_entry timeout state=%0d want 1", state); end
        n_tests++;
        if (proc_start !== 1'b1) begin n_fail++; $display("FAIL proc_start_pulse got %b want 1", proc_start); end
        n_tests++;
        if (pkt_len !== (AW+1)'(len)) begin n_fail++; $display("FAIL pkt_len got %0d want %0d", pkt_len, len); end
        @(negedge clk);
        n_tests++;
        if (proc_start !== 1'b0) begin n_fail++; $display("FAIL proc_start_width got %b want 0", proc_start); end
    endtask

    task automatic drain(input int n, input bit toggle);
        int got = 0, cyc = 0;
        bit exp_wr = 1'b0;
        logic [WW-1:0] w;
        @(negedge clk);
        proc_done = 1'b1; out_rdy = 1'b1;
        while (got < n && cyc < 100) begin
            @(negedge clk);
            proc_done = 1'b0; cyc++;
            n_tests++;
            if (out_wr !== exp_wr) begin n_fail++; $display("FAIL out_wr cycle %0d got %b want %b", cyc, out_wr, exp_wr); end
            if (out_wr === 1'b1) begin
                got++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL out_word extra word %h want none", {out_ctrl, out_data});
                end else begin
                    w = exp_q.pop_front();
                    if ({out_ctrl, out_data} !== w) begin
                        n_fail++; $display("FAIL out_word got %h want %h", {out_ctrl, out_data}, w);
                    end
                end
            end
            out_rdy = toggle ? ~cyc[0] : 1'b1;
            exp_wr  = (state == 2'd2) && out_rdy;
        end
        out_rdy = 1'b1;
        n_tests++;
        if (got != n) begin n_fail++; $display("FAIL drain_count got %0d want %0d", got, n); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; exp_q.delete();
        repeat (2) @(negedge clk);
        n_tests++;
        if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
        n_tests++;
        if ({out_wr, proc_start, ovf, state} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 00000", {out_wr, proc_start, ovf, state});
        end
        n_tests++;
        if ({out_ctrl, out_data, proc_dout, pkt_len} !== '0) begin
            n_fail++; $display("FAIL reset_data got %h/%h/%0d want 0", {out_ctrl, out_data}, proc_dout, pkt_len);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int c;
        send_pkt(5, 32'hA0A0_0001);
        wait_proc(5, c);
        n_tests++;
        if (c != 1) begin n_fail++; $display("FAIL handoff_latency got %0d want 1", c); end
        drain(5, 1'b0);
        n_tests++;
        if (state !== 2'd0) begin n_fail++; $display("FAIL basic_idle state=%0d want 0", state); end
    endtask

    task automatic test_proc_write();
        int c;
        logic [WW-1:0] nw = 72'h00_DEADBEEF00000000;
        send_pkt(5, 32'hB0B0_0002);
        wait_proc(5, c);
        proc_addr = 4'd2; proc_din = nw; proc_we = 1'b1;
        @(negedge clk);
        proc_we = 1'b0;
        n_tests++;
        if (proc_dout !== exp_q[2]) begin n_fail++; $display("FAIL proc_read_old got %h want %h", proc_dout, exp_q[2]); end
        @(negedge clk);
        n_tests++;
        if (proc_dout !== nw) begin n_fail++; $display("FAIL proc_read_new got %h want %h", proc_dout, nw); end
        exp_q[2] = nw;
        proc_addr = 4'd7;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (proc_dout !== '0) begin n_fail++; $display("FAIL proc_read_oob got %h want 0", proc_dout); end
        proc_addr = '0;
        drain(5, 1'b0);
    endtask

    task automatic test_out_rdy_toggle();
        int c;
        send_pkt(5, 32'hC0C0_0003);
        wait_proc(5, c);
        drain(5, 1'b1);
        n_tests++;
        if (state !== 2'd0) begin n_fail++; $display("FAIL toggle_idle state=%0d want 0", state); end
    endtask

    task automatic test_back_to_back();
        int c;
        send_pkt(5, 32'hD0D0_0004);
        wait_proc(5, c);
        send_pkt(6, 32'hD1D1_0005);
        n_tests++;
        if (state !== 2'd1) begin n_fail++; $display("FAIL b2b_still_proc state=%0d want 1", state); end
        drain(5, 1'b0);
        wait_proc(6, c);
        n_tests++;
        if (c != 1) begin n_fail++; $display("FAIL b2b_handoff got %0d want 1", c); end
        drain(6, 1'b0);
    endtask

    task automatic test_drop();
        int c;
        send_pkt(5, 32'hE0E0_0006);
        wait_proc(5, c);
        send_pkt(4, 32'hE1E1_0007);
`ifdef PKT_PROC_FIFO_DROP_EN
        proc_drop = 1'b1; proc_done = 1'b1;
        @(negedge clk);
        proc_drop = 1'b0; proc_done = 1'b0;
        n_tests++;
        if (state !== 2'd0 || out_wr !== 1'b0) begin
            n_fail++; $display("FAIL drop_idle state=%0d out_wr=%b want 0/0", state, out_wr);
        end
        repeat (5) void'(exp_q.pop_front());
        wait_proc(4, c);
        n_tests++;
        if (c != 1) begin n_fail++; $display("FAIL drop_handoff got %0d want 1", c); end
        drain(4, 1'b0);
`else
        proc_drop = 1'b1;
        repeat (2) @(negedge clk);
        proc_drop = 1'b0;
        n_tests++;
        if (state !== 2'd1 || out_wr !== 1'b0) begin
            n_fail++; $display("FAIL drop_ignored state=%0d out_wr=%b want 1/0", state, out_wr);
        end
        drain(5, 1'b0);
        wait_proc(4, c);
        drain(4, 1'b0);
`endif
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL drop_leftover got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_almost_full();
        bit acc;
        int c;
        test_reset();
        send_pkt(5, 32'hF0F0_0008);
        send_pkt(5, 32'hF1F1_0009);
        send_pkt(4, 32'hF2F2_000A);
        n_tests++;
        if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL almfull_rdy got %b want 0", in_rdy); end
        n_tests++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_before got %b want 0", ovf); end
        put_word(8'h00, 64'h0000_0BAD_0000_0BAD, acc);
        @(negedge clk);
        in_wr = 1'b0;
        n_tests++;
        if (acc) begin n_fail++; $display("FAIL overflow_word accepted, want discarded"); end
        n_tests++;
        if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_after got %b want 1", ovf); end
        drain(5, 1'b0);
        wait_proc(5, c);
        drain(5, 1'b0);
        wait_proc(4, c);
        drain(4, 1'b0);
        n_tests++;
        if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL almfull_recover got %b want 1", in_rdy); end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_proc_write();
        test_out_rdy_toggle();
        test_back_to_back();
        test_drop();
        test_almost_full();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
